// File: rtl/sub_mp_arbiter.sv
// Two-requester arbiter around one shared 32-bit subtractor.
// Performs WORDS x 32-bit unsigned subtraction, one word per cycle.

module full_sub_32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        bin_i,
  output logic [31:0] d_o,
  output logic        bout_o
);
  assign {bout_o, d_o} = {1'b0, a_i} - {1'b0, b_i} - {32'b0, bin_i};
endmodule

// state | meaning
// IDLE  | arbitrate between requesters, accept one operand pair
// RUN   | subtract word k, borrow carried in borrow_q
// DONE  | result held on res_* until the consumer takes it
module sub_mp_arbiter #(
  parameter int WORDS = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [32*WORDS-1:0] req0_x,
  input  logic [32*WORDS-1:0] req0_y,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [32*WORDS-1:0] req1_x,
  input  logic [32*WORDS-1:0] req1_y,
  output logic                res_valid,
  input  logic                res_ready,
  output logic                res_id,
  output logic [32*WORDS-1:0] res_d,
  output logic                res_bout,
  output logic                res_zero
);
  localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e                  state_q;
  logic [WORDS-1:0][31:0]  x_q, y_q, res_d_q, res_d_d;
  logic [KW-1:0]           k_q;
  logic                    borrow_q, last_grant_q;
  logic                    res_valid_q, res_id_q, res_bout_q, res_zero_q;
  logic                    grant;
  logic [31:0]             sub_d;
  logic                    sub_bout;

  // Round-robin only matters on a tie; a lone requester always wins.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ~last_grant_q;
    else                          grant = req1_valid;
  end

  assign req0_ready = (state_q == IDLE) && req0_valid && !grant;
  assign req1_ready = (state_q == IDLE) && req1_valid &&  grant;

  full_sub_32 u_sub (
    .a_i    (x_q[k_q]),
    .b_i    (y_q[k_q]),
    .bin_i  (borrow_q),
    .d_o    (sub_d),
    .bout_o (sub_bout)
  );

  always_comb begin
    res_d_d      = res_d_q;
    res_d_d[k_q] = sub_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      res_d_q      <= '0;
      k_q          <= '0;
      borrow_q     <= 1'b0;
      last_grant_q <= 1'b1;
      res_valid_q  <= 1'b0;
      res_id_q     <= 1'b0;
      res_bout_q   <= 1'b0;
      res_zero_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req0_ready || req1_ready) begin
            x_q          <= grant ? req1_x : req0_x;
            y_q          <= grant ? req1_y : req0_y;
            res_id_q     <= grant;
            last_grant_q <= grant;
            borrow_q     <= 1'b0;
            k_q          <= '0;
            res_d_q      <= '0;
            state_q      <= RUN;
          end
        end
        RUN: begin
          res_d_q  <= res_d_d;
          borrow_q <= sub_bout;
          if (k_q == KW'(WORDS - 1)) begin
            res_bout_q  <= sub_bout;
            res_zero_q  <= (res_d_d == '0);
            res_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign res_d     = res_d_q;
  assign res_bout  = res_bout_q;
  assign res_zero  = res_zero_q;
endmodule

// File: tb/tb_sub_mp_arbiter.sv
// Directed bench for sub_mp_arbiter: scoreboard of expected results keyed
// on accepts, plus latency, arbitration and hold checks.

module tb_sub_mp_arbiter;
  localparam int WORDS = 2;
  localparam int W     = 32 * WORDS;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_x = '0, req0_y = '0, req1_x = '0, req1_y = '0;
  logic         res_valid, res_ready = 1'b1, res_id, res_bout, res_zero;
  logic [W-1:0] res_d;

  always #5 clk = ~clk;

  sub_mp_arbiter #(.WORDS(WORDS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_x     (req0_x),
    .req0_y     (req0_y),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_x     (req1_x),
    .req1_y     (req1_y),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_id     (res_id),
    .res_d      (res_d),
    .res_bout   (res_bout),
    .res_zero   (res_zero)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc++;

  typedef struct packed {
    logic         id;
    logic [W-1:0] d;
    logic         bout;
    logic         zero;
  } exp_t;

  exp_t sb[$];
  bit   rec = 1'b0;
  int   acc_id[$];
  int   acc_cyc[$];

  function automatic exp_t model(input logic id, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] r;
    r          = {1'b0, x} - {1'b0, y};
    model.id   = id;
    model.d    = r[W-1:0];
    model.bout = r[W];
    model.zero = (r[W-1:0] == '0);
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs == exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: push on accept, pop on result handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      chk1("one_hot_ready", req0_ready & req1_ready, 1'b0);
      if (req0_valid && req0_ready) begin
        sb.push_back(model(1'b0, req0_x, req0_y));
        if (rec) begin acc_id.push_back(0); acc_cyc.push_back(cyc); end
      end
      if (req1_valid && req1_ready) begin
        sb.push_back(model(1'b1, req1_x, req1_y));
        if (rec) begin acc_id.push_back(1); acc_cyc.push_back(cyc); end
      end
      if (res_valid && res_ready) begin
        n_assert++;
        assert (sb.size() > 0) else begin
          n_fail++;
          $error("FAIL sb_underflow: observed result id=%b d=%h expected none", res_id, res_d);
        end
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          chk1("sb_id",   res_id,   e.id);
          chkw("sb_d",    res_d,    e.d);
          chk1("sb_bout", res_bout, e.bout);
          chk1("sb_zero", res_zero, e.zero);
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accept edge.
  task automatic send(input logic id, input logic [W-1:0] x, input logic [W-1:0] y);
    bit ok = 1'b0;
    if (id == 1'b0) begin req0_x = x; req0_y = y; req0_valid = 1'b1; end
    else            begin req1_x = x; req1_y = y; req1_valid = 1'b1; end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((id == 1'b0) ? req0_ready : req1_ready) begin ok = 1'b1; break; end
    end
    n_assert++;
    assert (ok) else begin
      n_fail++;
      $error("FAIL send_timeout: observed no ready expected ready within 20 cycles");
    end
    @(posedge clk); #1;
    if (id == 1'b0) req0_valid = 1'b0;
    else            req1_valid = 1'b0;
  endtask

  // Counts accept-relative edges until res_valid; ends on that negedge.
  task automatic wait_res(output int lat);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (res_valid) break;
      lat++;
    end
  endtask

  initial begin
    int lat;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk1("rst_valid", res_valid, 1'b0);
    chkw("rst_d",     res_d,     '0);
    chk1("rst_id",    res_id,    1'b0);
    chk1("rst_bout",  res_bout,  1'b0);
    chk1("rst_zero",  res_zero,  1'b0);
    @(posedge clk); #1;

    // 1: borrow across the word boundary
    send(1'b0, 64'h00000001_00000000, 64'h1);
    wait_res(lat);
    chki("t1_latency", lat, 2);
    chkw("t1_d",    res_d,    64'h00000000_FFFFFFFF);
    chk1("t1_bout", res_bout, 1'b0);
    chk1("t1_zero", res_zero, 1'b0);
    chk1("t1_id",   res_id,   1'b0);
    @(posedge clk); #1;

    // 2: full underflow from requester 1
    send(1'b1, 64'h0, 64'h1);
    wait_res(lat);
    chki("t2_latency", lat, 2);
    chkw("t2_d",    res_d,    64'hFFFFFFFF_FFFFFFFF);
    chk1("t2_bout", res_bout, 1'b1);
    chk1("t2_zero", res_zero, 1'b0);
    chk1("t2_id",   res_id,   1'b1);
    @(posedge clk); #1;

    // 3: equal operands
    send(1'b0, 64'h12345678_9ABCDEF0, 64'h12345678_9ABCDEF0);
    wait_res(lat);
    chkw("t3_d",    res_d,    64'h0);
    chk1("t3_zero", res_zero, 1'b1);
    chk1("t3_bout", res_bout, 1'b0);
    @(posedge clk); #1;

    // 4: both requesters valid continuously from reset
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.delete();
    rec = 1'b1;
    req0_x = 64'hAAAA0000_00000005; req0_y = 64'h00000001_00000009;
    req1_x = 64'h00000000_00000003; req1_y = 64'h00000000_00000007;
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (17) @(posedge clk);
    #1 req0_valid = 1'b0; req1_valid = 1'b0;
    rec = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !res_valid) break;
    end
    chki("t4_drain", sb.size(), 0);
    n_assert++;
    assert (acc_id.size() >= 4) else begin
      n_fail++;
      $error("FAIL t4_accepts: observed %0d accepts expected at least 4", acc_id.size());
    end
    for (int i = 0; i < 4 && i < acc_id.size(); i++)
      chki("t4_grant_order", acc_id[i], i % 2);
    for (int i = 0; i < 3 && i + 1 < acc_cyc.size(); i++)
      chki("t4_spacing", acc_cyc[i+1] - acc_cyc[i], 4);
    @(posedge clk); #1;

    // 5: consumer stalls while requester 1 waits
    res_ready = 1'b0;
    send(1'b0, 64'h10, 64'h3);
    req1_x = 64'h100; req1_y = 64'h1; req1_valid = 1'b1;
    wait_res(lat);
    chki("t5_latency", lat, 2);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk1("t5_hold_valid", res_valid,  1'b1);
      chkw("t5_hold_d",     res_d,      64'hD);
      chk1("t5_hold_id",    res_id,     1'b0);
      chk1("t5_hold_bout",  res_bout,   1'b0);
      chk1("t5_r0_low",     req0_ready, 1'b0);
      chk1("t5_r1_low",     req1_ready, 1'b0);
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    @(negedge clk);
    chk1("t5_r1_still_low", req1_ready, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk1("t5_r1_accept", req1_ready, 1'b1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    wait_res(lat);
    chki("t5b_latency", lat, 2);
    chkw("t5b_d",  res_d,  64'hFF);
    chk1("t5b_id", res_id, 1'b1);
    @(posedge clk); #1;

    // 6: reset after word 0 produced a borrow
    send(1'b0, 64'h0, 64'h1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.delete();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk1("t6_no_result", res_valid, 1'b0);
    end
    @(posedge clk); #1;
    send(1'b0, 64'h5, 64'h3);
    wait_res(lat);
    chki("t6_latency", lat, 2);
    chkw("t6_d",    res_d,    64'h2);
    chk1("t6_bout", res_bout, 1'b0);
    chk1("t6_zero", res_zero, 1'b0);
    @(posedge clk); #1;
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/sub_mp_arbiter.md
Name: sub_mp_arbiter

Overview:
- Shares one 32-bit ripple subtractor (existing full_sub_32 cell, single instance) between two requesters.
- Performs multi-word (WORDS x 32-bit) unsigned subtraction by sequencing the subtractor one word per cycle, least-significant word first.
- Chains the borrow through a register between words.
- Sits between operand producers and a consumer, using valid/ready handshakes on both sides.

Parameters:
- WORDS, 2, number of 32-bit words per operand; legal range 1..8. Operand width W = 32*WORDS.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- req0_valid  in  1  requester 0 has an operand pair
- req0_ready  out  1  requester 0 accepted this cycle when valid is also high
- req0_x  in  W  minuend, requester 0
- req0_y  in  W  subtrahend, requester 0
- req1_valid  in  1  requester 1 has an operand pair
- req1_ready  out  1  requester 1 accept
- req1_x  in  W  minuend, requester 1
- req1_y  in  W  subtrahend, requester 1
- res_valid  out  1  result available
- res_ready  in  1  consumer takes the result
- res_id  out  1  requester that owns the result
- res_d  out  W  x - y mod 2^W
- res_bout  out  1  final borrow (1 iff x < y, unsigned)
- res_zero  out  1  res_d == 0

Behaviour:
- Interface: one clock; reset is synchronous and active-low (clk, rst_n).
- Reset (rst_n low at a clk edge):
  - state = IDLE.
  - res_valid, res_id, res_d, res_bout, res_zero all 0.
  - Borrow register 0, word index 0.
  - last_grant = 1, so requester 0 wins the first tie.
  - Reset mid-RUN or mid-DONE discards the operation; nothing is emitted for it.
- States: IDLE, RUN, DONE.
- IDLE:
  - grant = the only valid requester. If both are valid, grant = the requester != last_grant.
  - reqN_ready = (state==IDLE) && reqN_valid && grant==N. It is combinational from the valids, and at most one ready is high.
  - On a handshake at edge T:
    - Latch x, y and id.
    - Clear borrow and word index k = 0; clear res_d.
    - last_grant <= id.
    - Go to RUN.
- RUN (cycle k):
  - Subtractor inputs: x word k, y word k, and the borrow register as bin.
  - Store the difference into res_d word k; borrow <= bout; k <= k+1.
  - After word WORDS-1: res_bout <= bout, res_zero <= (full difference == 0, including word WORDS-1), res_valid <= 1, go to DONE.
  - Latency: res_valid goes high at edge T+WORDS.
  - Both req_ready signals are low throughout RUN.
- DONE:
  - res_* are held stable while res_ready is low. No new accepts.
  - On the res_valid && res_ready edge: res_valid <= 0, go to IDLE. res_d, res_id, res_bout and res_zero keep their values.
  - The earliest next accept is the edge after the result handshake. Peak throughput is one operation per WORDS+2 cycles.
- Arithmetic:
  - Unsigned modulo 2^W; no overflow flag.
  - Borrow enters word 0 as 0 and propagates across words only through the registered borrow, never combinationally across words.
- Simultaneous events: a request arriving while busy must wait (its valid is held by the producer). A requester that drops valid before ready loses nothing.
- WORDS=1: RUN lasts exactly one cycle.

Test Plan:
1. WORDS=2, reset, then req0 x=0x00000001_00000000, y=0x1 -> res_valid exactly 2 cycles after accept; res_d=0x00000000_FFFFFFFF, res_bout=0, res_zero=0, res_id=0.
2. req1 x=0, y=1 -> res_d=0xFFFFFFFF_FFFFFFFF, res_bout=1, res_zero=0, res_id=1.
3. req0 x=y=0x12345678_9ABCDEF0 -> res_d=0, res_zero=1, res_bout=0.
4. Both valid continuously from reset with res_ready=1 -> grant order 0,1,0,1; accepts spaced 4 cycles apart; each result matches its own operands.
5. res_ready held low 5 cycles after res_valid -> res_* constant and req0_ready/req1_ready low throughout; raising res_ready returns to IDLE, and a pending request is accepted on the following edge.
6. rst_n low for one edge during RUN after word 0 produced a borrow (x=0, y=1) -> res_valid stays 0. The next request x=5, y=3 gives res_d=2, res_bout=0 (stale borrow not carried over).
